// File: rtl/cdr_ei_pkg.sv
// Shared defaults and helpers for the CDR + elastic-interface receive front end.
package cdr_ei_pkg;

    localparam int DEF_DATA_WIDTH      = 4;
    localparam int DEF_ADDR_WIDTH      = 2;
    localparam int DEF_SAMPLES_PER_BIT = 5;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ei_fifo.sv
// Synchronous elastic-interface FIFO with wrap-bit pointers, level flags,
// registered read data and registered one-cycle error pulses.
module ei_fifo
    import cdr_ei_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH:0]   write_count,
    output logic [ADDR_WIDTH:0]   read_count,
    output logic                  read_error,
    output logic                  write_error,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic                  do_push;
    logic                  do_pop;

    // Push and pop are single-cycle requests with no back-pressure: a pop
    // succeeds when not empty, a push succeeds when not full or when a pop
    // frees a slot in the same cycle; a refused request raises its error pulse.
    always_comb begin
        level        = wr_ptr - rd_ptr;
        full         = (level == DEPTH_L);
        empty        = (level == '0);
        almost_full  = (level >= DEPTH_L - ONE_L);
        almost_empty = (level <= ONE_L);
        do_pop       = pop && !empty;
        do_push      = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            read_data   <= '0;
            read_error  <= 1'b0;
            write_error <= 1'b0;
        end else begin
            read_error  <= pop && empty;
            write_error <= push && !do_push;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                read_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

    assign write_count = wr_ptr;
    assign read_count  = rd_ptr;

endmodule

// File: rtl/wrapper_cdr_ei.sv
// Receive front end: strobe-driven CDR, MSB-first deserializer and EI FIFO.
// Define CDR_MAJORITY_EN to vote over all samples; otherwise the centre sample decides.
module wrapper_cdr_ei
    import cdr_ei_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_phase,
    input  logic                  i_flag,
    input  logic                  inReadEnable,
    output logic [ADDR_WIDTH:0]   outWriteCount,
    output logic [ADDR_WIDTH:0]   outReadCount,
    output logic                  outReadError,
    output logic                  outWriteError,
    output logic                  outFull,
    output logic                  outEmpty,
    output logic                  outAlmostEmpty,
    output logic                  outAlmostFull,
    output logic                  outDone,
    output logic [DATA_WIDTH-1:0] outData
);

    localparam int SW = $clog2(SAMPLES_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);

    logic                  flag_q;
    logic                  strobe;
    logic                  last_sample;
    logic                  bit_val;
    logic [SW-1:0]         sample_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  push_q;
    logic [DATA_WIDTH-1:0] push_word;

    // A sample is the falling edge of the idle-high strobe line.
    assign strobe      = flag_q && !i_flag;
    assign last_sample = strobe && (sample_cnt == LAST_SAMPLE);
    assign shift_next  = {shift_reg[DATA_WIDTH-2:0], bit_val};

`ifdef CDR_MAJORITY_EN
    localparam logic [SW:0] HALF = (SW+1)'(SAMPLES_PER_BIT / 2);

    logic [SW:0] ones_cnt;
    logic [SW:0] ones_total;

    assign ones_total = ones_cnt + {{SW{1'b0}}, i_phase};
    assign bit_val    = (ones_total > HALF);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ones_cnt <= '0;
        end else if (last_sample) begin
            ones_cnt <= '0;
        end else if (strobe) begin
            ones_cnt <= ones_total;
        end
    end
`else
    localparam logic [SW-1:0] CENTRE = SW'(SAMPLES_PER_BIT / 2);

    logic centre_q;

    // The centre index always precedes the last one, so the capture is settled.
    assign bit_val = centre_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            centre_q <= 1'b0;
        end else if (strobe && (sample_cnt == CENTRE)) begin
            centre_q <= i_phase;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flag_q     <= 1'b1;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            push_q     <= 1'b0;
            push_word  <= '0;
        end else begin
            flag_q <= i_flag;
            push_q <= 1'b0;
            if (strobe) begin
                sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
            end
            if (last_sample) begin
                shift_reg <= shift_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    push_q    <= 1'b1;
                    push_word <= shift_next;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign outDone = push_q;

    ei_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk          (i_clk),
        .rst          (i_rst),
        .push         (push_q),
        .push_data    (push_word),
        .pop          (inReadEnable),
        .write_count  (outWriteCount),
        .read_count   (outReadCount),
        .read_error   (outReadError),
        .write_error  (outWriteError),
        .full         (outFull),
        .empty        (outEmpty),
        .almost_empty (outAlmostEmpty),
        .almost_full  (outAlmostFull),
        .read_data    (outData)
    );

endmodule

// File: tb/tb_wrapper_cdr_ei.sv
// Bench for wrapper_cdr_ei: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of sample groups, bit words and FIFO contents.
module tb_wrapper_cdr_ei;

    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int SPB   = 5;
    localparam int DEPTH = 1 << AW;
    localparam int CMOD  = 1 << (AW + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_phase = 1'b0;
    logic          i_flag = 1'b1;
    logic          inReadEnable = 1'b0;
    logic [AW:0]   outWriteCount;
    logic [AW:0]   outReadCount;
    logic          outReadError;
    logic          outWriteError;
    logic          outFull;
    logic          outEmpty;
    logic          outAlmostEmpty;
    logic          outAlmostFull;
    logic          outDone;
    logic [DW-1:0] outData;

    always #5 i_clk = ~i_clk;

    wrapper_cdr_ei #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .SAMPLES_PER_BIT (SPB)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_phase        (i_phase),
        .i_flag         (i_flag),
        .inReadEnable   (inReadEnable),
        .outWriteCount  (outWriteCount),
        .outReadCount   (outReadCount),
        .outReadError   (outReadError),
        .outWriteError  (outWriteError),
        .outFull        (outFull),
        .outEmpty       (outEmpty),
        .outAlmostEmpty (outAlmostEmpty),
        .outAlmostFull  (outAlmostFull),
        .outDone        (outDone),
        .outData        (outData)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model
    bit            m_flag_q;
    bit            samp_q[$];
    bit            bit_q[$];
    logic [DW-1:0] exp_q[$];
    bit            pend_push;
    logic [DW-1:0] pend_word;
    int            wcount, rcount;
    logic [DW-1:0] m_data;
    bit            m_done, m_werr, m_rerr;
    int            done_seen, rerr_seen, werr_seen;

    task automatic model_reset();
        m_flag_q  = 1'b1;
        samp_q.delete();
        bit_q.delete();
        exp_q.delete();
        pend_push = 1'b0;
        pend_word = '0;
        wcount    = 0;
        rcount    = 0;
        m_data    = '0;
        m_done    = 1'b0;
        m_werr    = 1'b0;
        m_rerr    = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit flag, input bit phase, input bit ren);
        bit            full, empty, b;
        int            ones;
        logic [DW-1:0] word;
        if (rst) begin
            model_reset();
            return;
        end
        full   = (exp_q.size() == DEPTH);
        empty  = (exp_q.size() == 0);
        m_rerr = ren && empty;
        m_werr = pend_push && full && !ren;
        if (ren && !empty) begin
            m_data = exp_q.pop_front();
            rcount++;
        end
        if (pend_push && !(full && !ren)) begin
            exp_q.push_back(pend_word);
            wcount++;
        end
        pend_push = 1'b0;
        if (m_flag_q && !flag) begin
            samp_q.push_back(phase);
            if (samp_q.size() == SPB) begin
                ones = 0;
                foreach (samp_q[i]) ones += samp_q[i];
`ifdef CDR_MAJORITY_EN
                b = (ones > SPB / 2);
`else
                b = samp_q[SPB / 2];
`endif
                samp_q.delete();
                bit_q.push_back(b);
                if (bit_q.size() == DW) begin
                    word = '0;
                    foreach (bit_q[i]) word = {word[DW-2:0], bit_q[i]};
                    bit_q.delete();
                    pend_push = 1'b1;
                    pend_word = word;
                end
            end
        end
        m_flag_q = flag;
        m_done   = pend_push;
    endtask

    task automatic compare_outputs();
        int lvl;
        lvl = exp_q.size();
        check("done",        outDone,        m_done);
        check("write_error", outWriteError,  m_werr);
        check("read_error",  outReadError,   m_rerr);
        check("data",        outData,        m_data);
        check("write_count", outWriteCount,  wcount % CMOD);
        check("read_count",  outReadCount,   rcount % CMOD);
        check("full",        outFull,        lvl == DEPTH);
        check("empty",       outEmpty,       lvl == 0);
        check("almost_full", outAlmostFull,  lvl >= DEPTH - 1);
        check("almost_empty",outAlmostEmpty, lvl <= 1);
    endtask

    // Driver: apply inputs for one cycle, advance the model, then compare
    task automatic step(input bit rst, input bit flag, input bit phase, input bit ren);
        i_rst        = rst;
        i_flag       = flag;
        i_phase      = phase;
        inReadEnable = ren;
        @(posedge i_clk);
        model_step(rst, flag, phase, ren);
        @(negedge i_clk);
        compare_outputs();
        if (outDone)       done_seen++;
        if (outReadError)  rerr_seen++;
        if (outWriteError) werr_seen++;
    endtask

    task automatic send_bit(input logic [SPB-1:0] samples);
        for (int i = 0; i < SPB; i++) begin
            step(1'b0, 1'b0, samples[i], 1'b0);
            for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic send_const(input bit b);
        send_bit({SPB{b}});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop_once();
        step(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] rec_bits;
        logic [3:0] maj_exp;
        logic [3:0] mid_bits;

        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_empty", outEmpty, 1'b1);
        check("reset_data",  outData,  '0);

        // Recovery: bits 0,1,1,1,1,1,1,0 -> words 0x7, 0xE
        done_seen = 0;
        rec_bits  = 8'b0111_1110;
        for (int i = 7; i >= 0; i--) send_const(rec_bits[i]);
        idle(3);
        check("rec_done_count",  done_seen,     2);
        check("rec_write_count", outWriteCount, 2);

        // Read out with six pops beyond empty
        rerr_seen = 0;
        for (int i = 0; i < 8; i++) begin
            pop_once();
            if (i == 0) check("rd_word0", outData, 4'h7);
            if (i == 1) check("rd_word1", outData, 4'hE);
        end
        idle(1);
        check("rd_error_count", rerr_seen,    6);
        check("rd_read_count",  outReadCount, 2);
        check("rd_empty",       outEmpty,     1'b1);

        // Majority versus centre-sample decision (samples listed LSB first)
        send_bit(5'b10101);
        send_bit(5'b01010);
        send_bit(5'b00110);
        send_bit(5'b11001);
        idle(2);
`ifdef CDR_MAJORITY_EN
        maj_exp = 4'h9;
`else
        maj_exp = 4'hA;
`endif
        pop_once();
        check("maj_word", outData, maj_exp);

        // Overflow: five words with no reads
        werr_seen = 0;
        for (int i = 0; i < 5 * DW; i++) send_const(1'($urandom_range(0, 1)));
        idle(3);
        check("ovf_full",        outFull,   1'b1);
        check("ovf_error_count", werr_seen, 1);
        for (int i = 0; i < 5; i++) pop_once();
        idle(1);

        // Reset mid-word, then 1,0,1,0 -> single 0xA
        send_const(1'b1);
        send_const(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        done_seen = 0;
        mid_bits  = 4'b1010;
        for (int i = 3; i >= 0; i--) send_const(mid_bits[i]);
        idle(3);
        check("mid_done_count", done_seen, 1);
        pop_once();
        check("mid_word", outData, 4'hA);
        idle(2);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
